// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - four-phase req/ack handshake initiator with ack synchronizer and timeout
//
// Carries one DATA_WIDTH word per handshake to a responder in an unrelated
// clock domain. The word is registered one cycle ahead of req_out so it is
// settled before the remote side can observe the request.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        synchronous active-low reset
//   send         start request, honoured only when idle
//   tx_data      word captured when send is accepted
//   ack_in       asynchronous acknowledge from the responder
//   req_out      registered handshake request
//   data_out     registered word, stable while req_out is high
//   busy         high from accepted send until back in idle
//   done         one-cycle pulse on successful completion
//   timeout_err  one-cycle pulse when ack never arrived in time
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  ack_in,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_REQ_HI = 3'd2,
        S_REQ_LO = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_meta_q, ack_meta_d;
    logic                  ack_sync_q, ack_sync_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  timeout_hit;

    // Two-flop synchronizer: only ack_sync_q is allowed to reach the FSM.
    always_comb begin
        ack_meta_d = ack_in;
        ack_sync_d = ack_meta_q;
    end

    assign timeout_hit = (cnt_q == CNT_LIMIT);

    // State register plus all datapath/output flops.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_meta_q <= ack_meta_d;
            ack_sync_q <= ack_sync_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. In REQ_HI an ack seen on the final counted cycle
    // takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (send) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_REQ_HI;
            end
            S_REQ_HI: begin
                if (ack_sync_q)       state_d = S_REQ_LO;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_REQ_LO: begin
                if (!ack_sync_q) state_d = S_IDLE;
            end
            S_ERR: begin
                // Wait for the responder to release ack so a late ack cannot
                // be mistaken for the answer to the next request.
                if (!ack_sync_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath logic: computes the next value of every registered output.
    always_comb begin
        req_d  = req_q;
        data_d = data_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send) begin
                    data_d = tx_data;
                    busy_d = 1'b1;
                end
            end
            S_SETUP: begin
                req_d = 1'b1;
                cnt_d = '0;
            end
            S_REQ_HI: begin
                if (ack_sync_q) begin
                    req_d = 1'b0;
                end else if (timeout_hit) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ_LO: begin
                if (!ack_sync_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_ERR: begin
                if (!ack_sync_q) busy_d = 1'b0;
            end
            default: begin
                req_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign req_out     = req_q;
    assign data_out    = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule
